// File: rtl/ttfir_sequencer_if.sv
// Bundle of host, stream, FIR and result signals for the 4-tap FIR sequencer.
// master = sequencer side, slave = surrounding logic.
interface ttfir_sequencer_if #(
   parameter int BW_in  = 6,
   parameter int BW_out = 8,
   parameter int AW     = 2
);
   logic              start;
   logic              lsb_mode;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [BW_in-1:0]  coef_data;
   logic              s_valid;
   logic              s_ready;
   logic [BW_in-1:0]  s_data;
   logic              fir_rst;
   logic              fir_step;
   logic [BW_in-1:0]  fir_x;
   logic [BW_out-1:0] fir_y;
   logic              m_valid;
   logic              m_ready;
   logic [BW_out-1:0] m_msb;
   logic [BW_out-1:0] m_lsb;
   logic              busy;

   modport master (
      input  start, lsb_mode, coef_we, coef_addr, coef_data,
      input  s_valid, s_data, fir_y, m_ready,
      output s_ready, fir_rst, fir_step, fir_x,
      output m_valid, m_msb, m_lsb, busy
   );

   modport slave (
      output start, lsb_mode, coef_we, coef_addr, coef_data,
      output s_valid, s_data, fir_y, m_ready,
      input  s_ready, fir_rst, fir_step, fir_x,
      input  m_valid, m_msb, m_lsb, busy
   );
endinterface

// File: rtl/ttfir_sequencer.sv
// Sequencer owning all step timing of the 4-tap FIR: reset, mode, coefficient
// load, then per-sample streaming with one result per accepted sample.
module ttfir_sequencer #(
   parameter int N_TAPS = 4,
   parameter int BW_in  = 6,
   parameter int BW_out = 8
) (
   input  logic              clk,
   input  logic              reset,
   ttfir_sequencer_if.master bus
);
   localparam int KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRST,
      S_MODE,
      S_COEF,
      S_RUN,
      S_CAP,
      S_SHIFT,
      S_CAPL
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [KW-1:0]     r_k;
   logic [KW-1:0]     w_k_next;
   logic              r_lsb_mode;
   logic [BW_in-1:0]  r_coef [N_TAPS];
   logic [BW_out-1:0] r_msb;
   logic [BW_out-1:0] r_lsb;
   logic              r_m_valid;

   logic              w_step;
   logic              w_frst;
   logic [BW_in-1:0]  w_x;
   logic              w_s_ready;
   logic              w_latch_mode;
   logic              w_cap_msb;
   logic              w_cap_lsb;
   logic              w_set_valid;
   logic              w_coef_wr;

   assign w_coef_wr = (r_state == S_IDLE) && bus.coef_we
                    && (int'(bus.coef_addr) < N_TAPS);

   always_comb begin
      w_next       = r_state;
      w_k_next     = r_k;
      w_step       = 1'b0;
      w_frst       = 1'b0;
      w_x          = '0;
      w_s_ready    = 1'b0;
      w_latch_mode = 1'b0;
      w_cap_msb    = 1'b0;
      w_cap_lsb    = 1'b0;
      w_set_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_latch_mode = 1'b1;
               w_next       = S_FRST;
            end
         end
         S_FRST: begin
            w_step = 1'b1;
            w_frst = 1'b1;
            w_next = S_MODE;
         end
         S_MODE: begin
            w_step   = 1'b1;
            w_x      = BW_in'(r_lsb_mode);
            w_k_next = KW'(N_TAPS - 1);
            w_next   = S_COEF;
         end
         S_COEF: begin
            // Highest index first so coef 0 ends up in tap 0.
            w_step = 1'b1;
            w_x    = r_coef[r_k];
            if (r_k == '0) begin
               w_next = S_RUN;
            end else begin
               w_k_next = r_k - KW'(1);
            end
         end
         S_RUN: begin
            w_s_ready = !r_m_valid;
            if (w_s_ready && bus.s_valid) begin
               w_step = 1'b1;
               w_x    = bus.s_data;
               w_next = S_CAP;
            end
         end
         S_CAP: begin
            w_cap_msb = 1'b1;
            if (r_lsb_mode) begin
               w_next = S_SHIFT;
            end else begin
               w_set_valid = 1'b1;
               w_next      = S_RUN;
            end
         end
         S_SHIFT: begin
            w_step = 1'b1;
            w_next = S_CAPL;
         end
         S_CAPL: begin
            w_cap_lsb   = 1'b1;
            w_set_valid = 1'b1;
            w_next      = S_RUN;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         r_k     <= w_k_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lsb_mode <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) begin
            r_coef[i] <= '0;
         end
      end else begin
         if (w_latch_mode) begin
            r_lsb_mode <= bus.lsb_mode;
         end
         if (w_coef_wr) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_msb     <= '0;
         r_lsb     <= '0;
         r_m_valid <= 1'b0;
      end else begin
         if (w_cap_msb) begin
            r_msb <= bus.fir_y;
            r_lsb <= '0;
         end
         if (w_cap_lsb) begin
            r_lsb <= bus.fir_y;
         end
         if (w_set_valid) begin
            r_m_valid <= 1'b1;
         end else if (r_m_valid && bus.m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign bus.fir_step = w_step;
   assign bus.fir_rst  = w_frst;
   assign bus.fir_x    = w_x;
   assign bus.s_ready  = w_s_ready;
   assign bus.m_valid  = r_m_valid;
   assign bus.m_msb    = r_msb;
   assign bus.m_lsb    = r_lsb;
   assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_ttfir_sequencer.sv
// Directed bench for ttfir_sequencer with a one-register FIR response model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_ttfir_sequencer;
   logic clk;
   logic reset;
   int   n_err;
   int   n_chk;
   logic [7:0] fy_next;
   logic [5:0] seq1 [6];
   logic [5:0] seq3 [6];

   ttfir_sequencer_if bus ();

   ttfir_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) bus.fir_y <= '0;
      else if (bus.fir_step) bus.fir_y <= fy_next;
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      fy_next = 8'h00;
      seq1[0] = 6'd0; seq1[1] = 6'd0; seq1[2] = 6'd4;
      seq1[3] = 6'd3; seq1[4] = 6'd2; seq1[5] = 6'd1;
      seq3[0] = 6'd0;  seq3[1] = 6'd1;  seq3[2] = 6'h09;
      seq3[3] = 6'h3E; seq3[4] = 6'h05; seq3[5] = 6'h21;
      reset = 1'b1;
      bus.start = 0; bus.lsb_mode = 0; bus.coef_we = 0;
      bus.coef_addr = 0; bus.coef_data = 0;
      bus.s_valid = 0; bus.s_data = 0; bus.m_ready = 0;

      // reset state
      tick(); tick(); #1;
      chk("rst_step", bus.fir_step, 0);
      chk("rst_frst", bus.fir_rst, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mvalid", bus.m_valid, 0);
      chk("rst_sready", bus.s_ready, 0);
      chk("rst_msb", bus.m_msb, 0);
      chk("rst_lsb", bus.m_lsb, 0);
      tick(); reset = 0;

      // 1: coefficient load and configure burst
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.coef_we = 1; bus.coef_addr = 2'(i); bus.coef_data = 6'(i + 1);
      end
      tick(); bus.coef_we = 0; bus.start = 1; bus.lsb_mode = 0;
      #1 chk("idle_busy", bus.busy, 0);
      for (int i = 0; i < 6; i++) begin
         tick(); bus.start = 0; #1;
         chk($sformatf("cfg1_step%0d", i), bus.fir_step, 1);
         chk($sformatf("cfg1_rst%0d", i), bus.fir_rst, (i == 0) ? 1 : 0);
         chk($sformatf("cfg1_x%0d", i), bus.fir_x, seq1[i]);
         chk($sformatf("cfg1_busy%0d", i), bus.busy, 1);
      end
      tick(); #1;
      chk("run1_step", bus.fir_step, 0);
      chk("run1_sready", bus.s_ready, 1);

      // 2: two samples, lsb_mode=0
      bus.m_ready = 1; bus.s_valid = 1; bus.s_data = 6'd5; fy_next = 8'h12;
      #1 chk("s5_step", bus.fir_step, 1);
      chk("s5_x", bus.fir_x, 6'd5);
      tick(); bus.s_valid = 0; #1;
      chk("s5_cap_step", bus.fir_step, 0);
      chk("s5_cap_mv", bus.m_valid, 0);
      chk("s5_cap_sready", bus.s_ready, 0);
      tick(); #1;
      chk("s5_mv", bus.m_valid, 1);
      chk("s5_msb", bus.m_msb, 8'h12);
      chk("s5_lsb", bus.m_lsb, 0);
      chk("s5_bp", bus.s_ready, 0);
      bus.s_valid = 1; bus.s_data = 6'h3D; fy_next = 8'h34;
      tick(); #1;
      chk("sm3_mv_clr", bus.m_valid, 0);
      chk("sm3_sready", bus.s_ready, 1);
      chk("sm3_step", bus.fir_step, 1);
      chk("sm3_x", bus.fir_x, 6'h3D);
      tick(); bus.s_valid = 0; #1;
      chk("sm3_cap_mv", bus.m_valid, 0);
      tick(); #1;
      chk("sm3_mv", bus.m_valid, 1);
      chk("sm3_msb", bus.m_msb, 8'h34);
      chk("sm3_lsb", bus.m_lsb, 0);
      tick(); #1;
      chk("sm3_done", bus.m_valid, 0);

      // 5: start and coef_we ignored in RUN
      bus.start = 1; bus.coef_we = 1; bus.coef_addr = 0; bus.coef_data = 6'h3F;
      #1 chk("run_ign_step0", bus.fir_step, 0);
      tick(); bus.start = 0; bus.coef_we = 0; #1;
      chk("run_ign_step1", bus.fir_step, 0);
      chk("run_ign_frst", bus.fir_rst, 0);
      chk("run_ign_sready", bus.s_ready, 1);
      chk("run_ign_busy", bus.busy, 1);

      // 4: back-pressure
      bus.m_ready = 0; bus.s_valid = 1; bus.s_data = 6'd1; fy_next = 8'h55;
      #1 chk("bp_step", bus.fir_step, 1);
      tick(); tick(); #1;
      chk("bp_mv", bus.m_valid, 1);
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         chk($sformatf("bp_sready%0d", i), bus.s_ready, 0);
         chk($sformatf("bp_mv%0d", i), bus.m_valid, 1);
         chk($sformatf("bp_msb%0d", i), bus.m_msb, 8'h55);
         chk($sformatf("bp_step%0d", i), bus.fir_step, 0);
      end
      tick(); bus.m_ready = 1; bus.s_data = 6'd2; fy_next = 8'h66; #1;
      chk("bp_hs_mv", bus.m_valid, 1);
      chk("bp_hs_sready", bus.s_ready, 0);
      tick(); bus.m_ready = 0; #1;
      chk("bp_after_mv", bus.m_valid, 0);
      chk("bp_after_sready", bus.s_ready, 1);
      chk("bp_after_step", bus.fir_step, 1);
      chk("bp_after_x", bus.fir_x, 6'd2);
      tick(); bus.s_valid = 0;
      tick(); #1;
      chk("bp2_msb", bus.m_msb, 8'h66);
      chk("bp2_mv", bus.m_valid, 1);
      bus.m_ready = 1;
      tick(); #1;
      chk("bp2_clr", bus.m_valid, 0);

      // 3: lsb_mode=1 with writes/start ignored during COEF
      reset = 1; #1;
      chk("rst3_busy", bus.busy, 0);
      chk("rst3_sready", bus.s_ready, 0);
      tick(); tick(); reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); bus.coef_we = 1; bus.coef_addr = 2'(i);
         bus.coef_data = (i == 0) ? 6'h21 : (i == 1) ? 6'h05 :
                         (i == 2) ? 6'h3E : 6'h09;
      end
      tick(); bus.coef_we = 0; bus.start = 1; bus.lsb_mode = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         bus.start = (i == 3) ? 1'b1 : 1'b0;
         bus.coef_we = (i == 3) ? 1'b1 : 1'b0;
         bus.coef_addr = 0; bus.coef_data = 6'd7;
         #1;
         chk($sformatf("cfg3_step%0d", i), bus.fir_step, 1);
         chk($sformatf("cfg3_x%0d", i), bus.fir_x, seq3[i]);
      end
      tick(); bus.start = 0; bus.coef_we = 0;
      bus.m_ready = 1; bus.s_valid = 1; bus.s_data = 6'd7; fy_next = 8'hA0;
      #1 chk("l7_step", bus.fir_step, 1);
      chk("l7_x", bus.fir_x, 6'd7);
      tick(); bus.s_valid = 0; fy_next = 8'h40; #1;
      chk("l7_cap_step", bus.fir_step, 0);
      tick(); #1;
      chk("l7_shift_step", bus.fir_step, 1);
      chk("l7_shift_x", bus.fir_x, 0);
      chk("l7_shift_mv", bus.m_valid, 0);
      tick(); #1;
      chk("l7_capl_step", bus.fir_step, 0);
      chk("l7_capl_mv", bus.m_valid, 0);
      tick(); #1;
      chk("l7_mv", bus.m_valid, 1);
      chk("l7_msb", bus.m_msb, 8'hA0);
      chk("l7_lsb", bus.m_lsb, 8'h40);
      tick(); #1;
      chk("l7_clr", bus.m_valid, 0);
      chk("l7_sready", bus.s_ready, 1);

      // 6: reset during COEF (k=2)
      reset = 1; tick(); tick(); reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); bus.coef_we = 1; bus.coef_addr = 2'(i);
         bus.coef_data = 6'(i + 1);
      end
      tick(); bus.coef_we = 0; bus.start = 1; bus.lsb_mode = 0;
      tick(); bus.start = 0;
      tick(); tick(); tick(); #1;
      chk("r6_k2_x", bus.fir_x, 6'd3);
      reset = 1; #1;
      chk("r6_async_step", bus.fir_step, 0);
      chk("r6_async_busy", bus.busy, 0);
      tick(); #1;
      chk("r6_hold_step", bus.fir_step, 0);
      reset = 0;
      tick(); #1;
      chk("r6_idle_step", bus.fir_step, 0);
      bus.start = 1; bus.lsb_mode = 1;
      for (int i = 0; i < 6; i++) begin
         tick(); bus.start = 0; #1;
         chk($sformatf("cfg6_step%0d", i), bus.fir_step, 1);
         chk($sformatf("cfg6_rst%0d", i), bus.fir_rst, (i == 0) ? 1 : 0);
         chk($sformatf("cfg6_x%0d", i), bus.fir_x, (i == 1) ? 1 : 0);
      end
      tick(); #1;
      chk("cfg6_end_step", bus.fir_step, 0);
      chk("cfg6_end_sready", bus.s_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
